mte_packet_framer: RTL and testbench
====================================

MTE_PACKET_FRAMER -- requirements
Module: mte_packet_framer

Interface
REQ-001 Parameter N, default 8, byte width of the data path.
REQ-002 Parameter DEPTH, default 32, maximum frame length in bytes.
REQ-003 Parameter EOF_BYTE, default 8'h03, end-of-frame marker value.
REQ-004 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  upstream byte present.
REQ-007 in_data  input  N  upstream byte.
REQ-008 in_mode  input  1  frame mode: 1 = encrypt, 0 = decrypt; sampled with the first byte of a frame.
REQ-009 in_ready  output  1  framer accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data valid toward the MtE stage.
REQ-011 out_data  output  N  byte to the MtE IN port.
REQ-012 out_sel  output  1  latched frame mode, drives the MtE sel port.
REQ-013 out_sof / out_eof  output  1 each  first / last byte of the drained frame.
REQ-014 frame_len  output  $clog2(DEPTH+1)  stored byte count of the frame being drained.
REQ-015 err_overflow  output  1  one-cycle pulse when a frame is truncated at DEPTH.

Function
REQ-016 The framer SHALL implement states IDLE, FILL and DRAIN.
REQ-017 IDLE: in_ready=1; a transfer (in_valid&in_ready) SHALL store the byte at index 0, latch in_mode into out_sel, set count=1, and go to FILL. If that byte equals EOF_BYTE, it SHALL go straight to DRAIN.
REQ-018 FILL: in_ready=1; each transfer SHALL store the byte at index count and increment count.
REQ-019 FILL to DRAIN SHALL occur on the cycle a transfer carries EOF_BYTE; the EOF byte is stored and forwarded.
REQ-020 When a transfer brings count to DEPTH without EOF_BYTE, the framer SHALL go to DRAIN and pulse err_overflow in the following cycle.
REQ-021 DRAIN: in_ready=0; one byte SHALL be emitted per clock with out_valid=1, starting the cycle after entry. There is no backpressure.
REQ-022 out_sof SHALL be 1 on the first drained byte only; out_eof SHALL be 1 on the last drained byte only.
REQ-023 frame_len SHALL equal the stored count and be stable throughout DRAIN.
REQ-024 On the cycle after the last drained byte, the framer SHALL return to IDLE, with in_ready=1 in that cycle.
REQ-025 A change of in_mode during FILL or DRAIN SHALL have no effect on out_sel for the current frame.
REQ-026 in_data SHALL be ignored whenever in_ready=0 or in_valid=0.
REQ-027 Counters SHALL never wrap: count saturates at DEPTH, and the read index stops at the last byte.

Reset
REQ-028 While reset_n=0: state=IDLE; in_ready=0 during reset, then 1 in IDLE.
REQ-029 While reset_n=0, all of the following SHALL be 0: out_valid, out_data, out_sel, out_sof, out_eof, frame_len, err_overflow and count.
REQ-030 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial frame with no further out_valid.
REQ-031 Buffer contents need not be cleared by reset.

Configuration
REQ-032 With MTE_FRAMER_PAD_EN defined, DRAIN SHALL always emit DEPTH bytes. Bytes past the stored count SHALL be 8'h00, and out_eof SHALL fall on byte DEPTH-1.
REQ-033 Without MTE_FRAMER_PAD_EN, DRAIN SHALL emit exactly frame_len bytes.

Structure
REQ-034 Package mte_pkg SHALL hold MTE_N, MTE_DEPTH, MTE_EOF_BYTE and the state enum typedef framer_state_t.
REQ-035 Storage SHALL be a sub-module mte_byte_buffer: a DEPTH x N register file with one write port and one combinational read port, no reset.

Verification
REQ-036 Send 41 42 03, mode=1 -> next cycle, 3 bytes out 41 42 03 with out_sel=1, sof on 41, eof on 03, frame_len=3; in_ready=0 for 3 cycles.
REQ-037 Send 32 non-03 bytes 00..1F (skipping 03 by using 20 instead), mode=0 -> err_overflow pulse, 32 bytes out, out_sel=0, frame_len=32.
REQ-038 Send a single 03 byte -> 1 byte out with sof=eof=1 and frame_len=1.
REQ-039 Send AA 55 03 with MTE_FRAMER_PAD_EN defined -> 32 bytes out: AA 55 03, then 29 x 00, eof on byte 31, frame_len=3.
REQ-040 Deassert reset_n mid-DRAIN at byte 2 of 10 -> out_valid=0 immediately; the next frame drains correctly from index 0.
REQ-041 Toggle in_mode and in_valid every cycle during FILL -> only valid bytes stored, out_sel equals the mode sampled with the first byte.

Source files
------------

// File: rtl/mte_pkg.sv
// Shared constants and types for the MtE packet framer.
// Optional build macro recognised by the framer: MTE_FRAMER_PAD_EN.
package mte_pkg;

  localparam int         MTE_N        = 8;
  localparam int         MTE_DEPTH    = 32;
  localparam logic [7:0] MTE_EOF_BYTE = 8'h03;

  // Framer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } framer_state_t;

endpackage

// File: rtl/mte_packet_framer_if.sv
// Byte-stream bus between an upstream producer, the framer and the MtE stage.
//
// Handshake: an input byte is transferred on a rising clock edge where
// in_valid and in_ready are both 1; in_data/in_mode are don't-care otherwise.
// The output side has no backpressure: every cycle with out_valid=1 carries
// one byte that the MtE stage must take.
interface mte_packet_framer_if
  import mte_pkg::*;
#(
  parameter int N     = MTE_N,
  parameter int DEPTH = MTE_DEPTH
) ();

  logic                       in_valid;
  logic [N-1:0]               in_data;
  logic                       in_mode;
  logic                       in_ready;
  logic                       out_valid;
  logic [N-1:0]               out_data;
  logic                       out_sel;
  logic                       out_sof;
  logic                       out_eof;
  logic [$clog2(DEPTH+1)-1:0] frame_len;
  logic                       err_overflow;

  // Producer / consumer side (testbench or surrounding logic).
  modport master (
    output in_valid, in_data, in_mode,
    input  in_ready, out_valid, out_data, out_sel, out_sof, out_eof,
    input  frame_len, err_overflow
  );

  // Framer side.
  modport slave (
    input  in_valid, in_data, in_mode,
    output in_ready, out_valid, out_data, out_sel, out_sof, out_eof,
    output frame_len, err_overflow
  );

endinterface

// File: rtl/mte_byte_buffer.sv
// Frame storage: DEPTH x N register file, one write port, one
// combinational read port. Contents are not reset.
module mte_byte_buffer #(
  parameter int N     = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem_q [DEPTH];

  // Write port: store one byte per accepted transfer.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mte_packet_framer.sv
// MtE packet framer: collects a frame of bytes terminated by EOF_BYTE (or
// truncated at DEPTH), then drains it one byte per cycle toward the MtE
// stage with sof/eof markers and the latched frame mode on out_sel.
// Build macro: MTE_FRAMER_PAD_EN -- when defined, every drain emits DEPTH
// bytes, zero-filled past the stored length.
module mte_packet_framer
  import mte_pkg::*;
#(
  parameter int           N        = MTE_N,
  parameter int           DEPTH    = MTE_DEPTH,
  parameter logic [N-1:0] EOF_BYTE = MTE_EOF_BYTE
) (
  input  logic                clock,
  input  logic                reset_n,
  mte_packet_framer_if.slave  bus,
  output framer_state_t       dbg_state
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  framer_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] len_q, len_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  data_q, data_d;
  logic          sel_q, sel_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic          ovf_q, ovf_d;

  logic          xfer;
  logic          is_eof;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] drain_last;
  logic          single_emit;
  logic [N-1:0]  drain_byte;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;

  // Transfer qualification and write addressing for the buffer.
  always_comb begin
    xfer      = bus.in_valid & ready_q;
    is_eof    = (bus.in_data == EOF_BYTE);
    if (state_q == ST_IDLE) begin
      count_inc = ONE_C;
    end else if (count_q == DEPTH_C) begin
      count_inc = count_q;
    end else begin
      count_inc = count_q + ONE_C;
    end
    wr_addr = (state_q == ST_IDLE) ? '0 : count_q[AW-1:0];
    rd_addr = (state_q == ST_DRAIN) ? rd_idx_q[AW-1:0] : '0;
  end

  mte_byte_buffer #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clock (clock),
    .we    (xfer),
    .waddr (wr_addr),
    .wdata (bus.in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Drain geometry: index of the final emitted byte and the byte at rd_idx.
`ifdef MTE_FRAMER_PAD_EN
  always_comb begin
    drain_last  = DEPTH_C - ONE_C;
    single_emit = (DEPTH == 1);
    drain_byte  = (rd_idx_q >= len_q) ? '0 : rd_data;
  end
`else
  always_comb begin
    drain_last  = len_q - ONE_C;
    single_emit = (count_inc == ONE_C);
    drain_byte  = rd_data;
  end
`endif

  // Next-state and next-output logic for the IDLE/FILL/DRAIN controller.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    len_d    = len_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    data_d   = data_q;
    sel_d    = sel_q;
    sof_d    = sof_q;
    eof_d    = eof_q;
    ovf_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        ready_d = 1'b1;
        if (xfer) begin
          count_d = count_inc;
          if (state_q == ST_IDLE) begin
            sel_d = bus.in_mode;
          end
          if (is_eof || (count_inc == DEPTH_C)) begin
            // First byte goes out on the very next cycle; a one-byte frame
            // has not landed in the buffer yet, so take it from the bus.
            state_d  = ST_DRAIN;
            ready_d  = 1'b0;
            valid_d  = 1'b1;
            sof_d    = 1'b1;
            eof_d    = single_emit;
            data_d   = (state_q == ST_IDLE) ? bus.in_data : rd_data;
            len_d    = count_inc;
            rd_idx_d = ONE_C;
            ovf_d    = ~is_eof;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_DRAIN: begin
        if (eof_q) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eof_d   = 1'b0;
          data_d  = '0;
        end else begin
          valid_d  = 1'b1;
          sof_d    = 1'b0;
          data_d   = drain_byte;
          eof_d    = (rd_idx_q == drain_last);
          rd_idx_d = (rd_idx_q == drain_last) ? rd_idx_q : rd_idx_q + ONE_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs; reset discards any frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_idx_q <= '0;
      len_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      sel_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      len_q    <= len_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready     = ready_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_data     = data_q;
  assign bus.out_sel      = sel_q;
  assign bus.out_sof      = sof_q;
  assign bus.out_eof      = eof_q;
  assign bus.frame_len    = len_q;
  assign bus.err_overflow = ovf_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mte_packet_framer.sv
// Directed bench for mte_packet_framer: frames are driven byte by byte, the
// expected drained bytes go into a queue, and a monitor compares every
// out_valid cycle against the queue head.
module tb_mte_packet_framer;
  import mte_pkg::*;

  localparam int N     = MTE_N;
  localparam int DEPTH = MTE_DEPTH;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int W     = N + 3 + LW;
`ifdef MTE_FRAMER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  framer_state_t dbg_state;

  always #5 clock = ~clock;

  mte_packet_framer_if #(.N(N), .DEPTH(DEPTH)) bus ();

  mte_packet_framer #(
    .N        (N),
    .DEPTH    (DEPTH),
    .EOF_BYTE (MTE_EOF_BYTE)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  logic [N-1:0] vec [64];
  int           total     = 0;
  int           bad       = 0;
  int           ovf_seen  = 0;
  int           ovf_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every presented byte must match the queue head.
  always @(negedge clock) begin
    if (bus.out_valid) begin
      mon_got = {bus.out_data, bus.out_sel, bus.out_sof, bus.out_eof, bus.frame_len};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out actual=%h required=none (data,sel,sof,eof,len)", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL out_byte actual=%h required=%h (data,sel,sof,eof,len)", mon_got, mon_exp);
        end
      end
    end
    if (bus.err_overflow) ovf_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.in_ready && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    check("wait_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // Send vec[0..n-1]; exp_len/exp_ovf are the hand-derived frame results.
  task automatic send_frame(input int n, input logic mode, input bit gaps,
                            input int exp_len, input bit exp_ovf,
                            input int keep, input bit check_drain);
    int           emit;
    int           k;
    logic [N-1:0] b;
    logic         m;
    emit = PAD ? DEPTH : exp_len;
    for (int i = 0; i < emit && i < keep; i++) begin
      b = (i < exp_len) ? vec[i] : '0;
      exp_q.push_back({b, mode, (i == 0), (i == emit - 1), LW'(exp_len)});
    end
    if (exp_ovf) ovf_total++;
    wait_ready();
    for (int i = 0; i < n; i++) begin
      m = gaps ? (mode ^ i[0]) : mode;
      if (gaps && i > 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = MTE_EOF_BYTE;
        bus.in_mode  = ~m;
        @(posedge clock); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      bus.in_mode  = m;
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_mode  = ~mode;
    check("first_byte_valid", 32'(bus.out_valid), 32'd1);
    check("overflow_pulse", 32'(bus.err_overflow), 32'(exp_ovf));
    if (check_drain) begin
      k = 0;
      while (!bus.in_ready && k < DEPTH + 10) begin
        @(posedge clock); #1;
        k++;
      end
      check("drain_ready_low_cycles", 32'(k), 32'(emit));
      check("idle_after_drain", 32'(dbg_state), 32'(ST_IDLE));
      check("no_valid_after_drain", 32'(bus.out_valid), 32'd0);
    end
  endtask

  task automatic check_reset_values();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_sel", 32'(bus.out_sel), 32'd0);
    check("rst_out_sof", 32'(bus.out_sof), 32'd0);
    check("rst_out_eof", 32'(bus.out_eof), 32'd0);
    check("rst_frame_len", 32'(bus.frame_len), 32'd0);
    check("rst_err_overflow", 32'(bus.err_overflow), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_mode  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values();
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);

    // 41 42 03, encrypt
    vec[0] = 8'h41; vec[1] = 8'h42; vec[2] = 8'h03;
    send_frame(3, 1'b1, 1'b0, 3, 1'b0, 1000, 1'b1);

    // 32 bytes without EOF, decrypt: truncated with overflow
    for (int i = 0; i < 32; i++) vec[i] = (i == 3) ? 8'h20 : 8'(i);
    send_frame(32, 1'b0, 1'b0, 32, 1'b1, 1000, 1'b1);

    // single EOF byte
    vec[0] = 8'h03;
    send_frame(1, 1'b1, 1'b0, 1, 1'b0, 1000, 1'b1);

    // AA 55 03 (zero-padded to DEPTH when padding is built in)
    vec[0] = 8'hAA; vec[1] = 8'h55; vec[2] = 8'h03;
    send_frame(3, 1'b0, 1'b0, 3, 1'b0, 1000, 1'b1);

    // EOF landing exactly on byte DEPTH: full frame, no overflow
    for (int i = 0; i < 31; i++) vec[i] = 8'h80 + 8'(i);
    vec[31] = 8'h03;
    send_frame(32, 1'b1, 1'b0, 32, 1'b0, 1000, 1'b1);

    // in_valid and in_mode toggling during FILL; gap cycles carry 03
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44; vec[4] = 8'h03;
    send_frame(5, 1'b1, 1'b1, 5, 1'b0, 1000, 1'b1);
    vec[0] = 8'h7A; vec[1] = 8'hC5; vec[2] = 8'h03;
    send_frame(3, 1'b0, 1'b1, 3, 1'b0, 1000, 1'b1);

    // reset while byte 2 of a 10-byte frame is on the output
    for (int i = 0; i < 9; i++) vec[i] = 8'h50 + 8'(i);
    vec[9] = 8'h03;
    send_frame(10, 1'b1, 1'b0, 10, 1'b0, 2, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("reset_kills_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clock); #1;
    check_reset_values();
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    check("ready_after_mid_reset", 32'(bus.in_ready), 32'd1);

    // next frame drains from index 0
    vec[0] = 8'h61; vec[1] = 8'h62; vec[2] = 8'h03;
    send_frame(3, 1'b0, 1'b0, 3, 1'b0, 1000, 1'b1);

    repeat (3) @(posedge clock);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("overflow_pulse_count", 32'(ovf_seen), 32'(ovf_total));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
